// File: rtl/nrs_est_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nrs_est_pkg                                                              |
// | Shared constants and helpers for the NRS least-squares channel estimator.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package nrs_est_pkg;

  localparam int NRS_AMP_Q11 = 1448;  // 0.7071 in Q.11
  localparam int NRS_FRAC    = 11;
  localparam int NRS_AMP_W   = 12;
  localparam int DEF_W       = 16;
  localparam int DEF_DEPTH   = 8;

  // NRS sign-bit decode applied to a sample: bit 0 keeps it, bit 1 negates it.
  function automatic int nrs_apply_sign(input logic neg, input int x);
    return neg ? -x : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmplx_pm_conj_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmplx_pm_conj_mult                                                       |
// | rx * conj(AMP*(+-1 +-j)) as a 2-register pipeline with a combinational   |
// | rounding/shift tail. Every register advances only when en is high.       |
// | Rev 1.0 - initial release                                                |
// |                                                                          |
// | Ports: clk, rst (async, active-low), en (stage enable), in_valid,        |
// |        rx_r/rx_i (W signed), nrs_r/nrs_i (sign bits),                    |
// |        out_valid (valid of est), est_r/est_i (W+1 signed)                |
// +--------------------------------------------------------------------------+
module cmplx_pm_conj_mult
  import nrs_est_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int FRAC  = NRS_FRAC,
  parameter int AMP   = NRS_AMP_Q11,
  parameter int AMP_W = NRS_AMP_W,
  parameter int ROUND = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic signed [W-1:0] rx_r,
  input  logic signed [W-1:0] rx_i,
  input  logic                nrs_r,
  input  logic                nrs_i,
  output logic                out_valid,
  output logic signed [W:0]   est_r,
  output logic signed [W:0]   est_i
);

  localparam int W1 = W + 1;
  localparam int W2 = W + 2;
  localparam int PW = W2 + AMP_W + 1;
  localparam logic signed [PW-1:0] AMP_P = PW'(AMP);
  localparam logic signed [PW-1:0] RND_P = (ROUND != 0) ? (PW'(1) <<< (FRAC - 1)) : '0;

  // a/b carry one extra bit: (-2^(W-1)) + (-2^(W-1)) with both signs negative
  // reaches +2^W, which does not fit in W+1 signed bits.
  logic signed [W2-1:0] a_d, b_d, a_q, b_q;
  logic signed [PW-1:0] pr_q, pi_q;
  logic                 v1;

  assign a_d = W2'(nrs_apply_sign(nrs_r, int'(rx_r)) + nrs_apply_sign(nrs_i, int'(rx_i)));
  assign b_d = W2'(nrs_apply_sign(nrs_r, int'(rx_i)) - nrs_apply_sign(nrs_i, int'(rx_r)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      pr_q      <= '0;
      pi_q      <= '0;
    end else if (en) begin
      v1        <= in_valid;
      a_q       <= a_d;
      b_q       <= b_d;
      out_valid <= v1;
      pr_q      <= PW'(a_q) * AMP_P;
      pi_q      <= PW'(b_q) * AMP_P;
    end
  end

  // AMP < 2^FRAC, so the scaled result always fits in W+1 bits.
  assign est_r = W1'((pr_q + RND_P) >>> FRAC);
  assign est_i = W1'((pi_q + RND_P) >>> FRAC);

endmodule
`default_nettype wire

// File: rtl/nrs_ls_estimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nrs_ls_estimator                                                         |
// | Streaming LS channel estimate at NRS REs with optional averaging of      |
// | symbol pairs. 3-cycle latency, valid/ready on both sides.                |
// | Rev 1.0 - initial release                                                |
// |                                                                          |
// | Ports: clk, rst (async, active-low), mode (0 per-symbol, 1 pair avg),    |
// |        in_valid/in_ready/in_last, rx_r/rx_i (W), nrs_r/nrs_i,            |
// |        out_valid/out_ready, out_r/out_i (W+1), out_idx, out_last         |
// +--------------------------------------------------------------------------+
module nrs_ls_estimator
  import nrs_est_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int FRAC  = NRS_FRAC,
  parameter int AMP   = NRS_AMP_Q11,
  parameter int AMP_W = NRS_AMP_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ROUND = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic signed [W-1:0]      rx_r,
  input  logic signed [W-1:0]      rx_i,
  input  logic                     nrs_r,
  input  logic                     nrs_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [W:0]        out_r,
  output logic signed [W:0]        out_i,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic                     out_last
);

  localparam int IW = $clog2(DEPTH);
  localparam int W1 = W + 1;
  localparam int W2 = W + 2;
  localparam logic signed [W2-1:0] RND1 = (ROUND != 0) ? W2'(1) : W2'(0);

  logic          adv, take, sym_end, eff_mode, eff_sym;
  logic [IW-1:0] idx;
  logic          sym, cur_mode;

  // Per-RE side information travelling alongside the two arithmetic registers.
  logic [IW-1:0] idx1, idx2;
  logic          last1, last2, avg1, avg2, sym1, sym2;

  logic                 v2, emit, wr_buf;
  logic signed [W:0]    est_r, est_i, avg_r, avg_i;
  logic signed [W2-1:0] sum_r, sum_i;
  logic signed [W:0]    mem_r [DEPTH];
  logic signed [W:0]    mem_i [DEPTH];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign take     = in_valid & adv;

  // Mode is only sampled on the first RE of a symbol. A symbol starting in
  // mode 0 always runs with sym=0, which also clears a pending sym=1.
  assign eff_mode = (idx == '0) ? mode : cur_mode;
  assign eff_sym  = eff_mode & sym;
  assign sym_end  = in_last | (idx == IW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      sym      <= 1'b0;
      cur_mode <= 1'b0;
    end else if (take) begin
      cur_mode <= eff_mode;
      if (sym_end) begin
        idx <= '0;
        sym <= eff_mode & ~eff_sym;
      end else begin
        idx <= idx + IW'(1);
        sym <= eff_sym;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx1  <= '0;
      idx2  <= '0;
      last1 <= 1'b0;
      last2 <= 1'b0;
      avg1  <= 1'b0;
      avg2  <= 1'b0;
      sym1  <= 1'b0;
      sym2  <= 1'b0;
    end else if (adv) begin
      idx1  <= idx;
      last1 <= sym_end;
      avg1  <= eff_mode;
      sym1  <= eff_sym;
      idx2  <= idx1;
      last2 <= last1;
      avg2  <= avg1;
      sym2  <= sym1;
    end
  end

  cmplx_pm_conj_mult #(
    .W     (W),
    .FRAC  (FRAC),
    .AMP   (AMP),
    .AMP_W (AMP_W),
    .ROUND (ROUND)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (take),
    .rx_r      (rx_r),
    .rx_i      (rx_i),
    .nrs_r     (nrs_r),
    .nrs_i     (nrs_i),
    .out_valid (v2),
    .est_r     (est_r),
    .est_i     (est_i)
  );

  // First symbol of an averaging pair is stored, not emitted. The second
  // reads its partner at the same index; in-order writes guarantee the
  // partner entry was written before it is read.
  assign wr_buf = adv & v2 & avg2 & ~sym2;
  assign emit   = v2 & ~(avg2 & ~sym2);
  assign sum_r  = W2'(mem_r[idx2]) + W2'(est_r);
  assign sum_i  = W2'(mem_i[idx2]) + W2'(est_i);
  assign avg_r  = W1'((sum_r + RND1) >>> 1);
  assign avg_i  = W1'((sum_i + RND1) >>> 1);

  always_ff @(posedge clk) begin
    if (wr_buf) begin
      mem_r[idx2] <= est_r;
      mem_i[idx2] <= est_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= emit;
      if (emit) begin
        out_r    <= avg2 ? avg_r : est_r;
        out_i    <= avg2 ? avg_i : est_i;
        out_idx  <= idx2;
        out_last <= last2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nrs_ls_estimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nrs_ls_estimator                                                      |
// | Self-checking bench: a truncating and a rounding instance share one      |
// | stimulus stream; a reference model queues expected beats.                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_nrs_ls_estimator;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic clk = 1'b0;
  logic rst, mode, in_valid, in_last, nrs_r, nrs_i, out_ready;
  logic signed [W-1:0] rx_r, rx_i;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic signed [W:0] out_r0, out_i0, out_r1, out_i1;
  logic [IW-1:0] out_idx0, out_idx1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    longint r0, i0, r1, i1;
    int     idx;
    bit     last;
    int     t_acc;
    bit     lat;
  } exp_t;

  exp_t   sbq[$];
  int     m_idx;
  bit     m_sym, m_mode;
  longint mb_r0[DEPTH], mb_i0[DEPTH], mb_r1[DEPTH], mb_i1[DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nrs_ls_estimator #(.W(W), .DEPTH(DEPTH), .ROUND(0)) u_dut0 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
    .in_last(in_last), .rx_r(rx_r), .rx_i(rx_i), .nrs_r(nrs_r), .nrs_i(nrs_i),
    .out_valid(out_valid0), .out_ready(out_ready), .out_r(out_r0), .out_i(out_i0),
    .out_idx(out_idx0), .out_last(out_last0)
  );

  nrs_ls_estimator #(.W(W), .DEPTH(DEPTH), .ROUND(1)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .rx_r(rx_r), .rx_i(rx_i), .nrs_r(nrs_r), .nrs_i(nrs_i),
    .out_valid(out_valid1), .out_ready(out_ready), .out_r(out_r1), .out_i(out_i1),
    .out_idx(out_idx1), .out_last(out_last1)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_sym  = 1'b0;
    m_mode = 1'b0;
  endtask

  // Reference model of one accepted RE; queues a beat unless it is the
  // stored half of an averaging pair.
  task automatic model_accept(input int r, input int i, input bit nr, input bit ni,
                              input bit last, input bit md, input bit lat, input int t);
    longint a, b, er0, ei0, er1, ei1;
    bit em, es, en;
    exp_t e;
    a   = longint'(nr ? -r : r) + longint'(ni ? -i : i);
    b   = longint'(nr ? -i : i) - longint'(ni ? -r : r);
    er0 = (a * 1448) >>> 11;
    ei0 = (b * 1448) >>> 11;
    er1 = (a * 1448 + 1024) >>> 11;
    ei1 = (b * 1448 + 1024) >>> 11;
    em  = (m_idx == 0) ? md : m_mode;
    es  = em & m_sym;
    en  = last || (m_idx == DEPTH - 1);
    if (em && !es) begin
      mb_r0[m_idx] = er0; mb_i0[m_idx] = ei0;
      mb_r1[m_idx] = er1; mb_i1[m_idx] = ei1;
    end else begin
      if (em) begin
        er0 = (mb_r0[m_idx] + er0) >>> 1;
        ei0 = (mb_i0[m_idx] + ei0) >>> 1;
        er1 = (mb_r1[m_idx] + er1 + 1) >>> 1;
        ei1 = (mb_i1[m_idx] + ei1 + 1) >>> 1;
      end
      e.r0 = er0; e.i0 = ei0; e.r1 = er1; e.i1 = ei1;
      e.idx = m_idx; e.last = en; e.t_acc = t; e.lat = lat;
      sbq.push_back(e);
    end
    m_mode = em;
    if (en) begin
      m_idx = 0;
      m_sym = em & !es;
    end else begin
      m_idx++;
      m_sym = es;
    end
  endtask

  task automatic send(input int r, input int i, input bit nr, input bit ni,
                      input bit last, input bit md, input bit lat);
    int n;
    rx_r = 16'(r); rx_i = 16'(i); nrs_r = nr; nrs_i = ni;
    in_last = last; mode = md; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) chk("accept_timeout", in_ready0, 1);
    else model_accept(r, i, nr, ni, last, md, lat, cyc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: sampled at the falling edge, i.e. the state seen by the
  // next rising edge's handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid0 && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_beat", out_valid0, 0);
      end else begin
        e = sbq.pop_front();
        chk("out_valid_round", out_valid1, 1);
        chk("out_r_trunc", out_r0, e.r0);
        chk("out_i_trunc", out_i0, e.i0);
        chk("out_r_round", out_r1, e.r1);
        chk("out_i_round", out_i1, e.i1);
        chk("out_idx", out_idx0, e.idx);
        chk("out_last", out_last0, e.last);
        chk("out_idx_round", out_idx1, e.idx);
        chk("out_last_round", out_last1, e.last);
        if (e.lat) chk("latency", cyc - e.t_acc, 3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    rx_r = '0; rx_i = '0; nrs_r = 1'b0; nrs_i = 1'b0; out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_r", out_r0, 0);
    chk("rst_out_i", out_i0, 0);
    chk("rst_out_idx", out_idx0, 0);
    chk("rst_out_last", out_last0, 0);
    chk("rst_in_ready", in_ready0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single REs, idle pipeline: sign patterns, rounding, extremes, latency
    send(-1, -1, 0, 0, 1, 0, 1);          drain();
    send(-1, -1, 1, 1, 1, 0, 1);          drain();
    send(-1, -1, 1, 0, 1, 0, 1);          drain();
    send(-1, -1, 0, 1, 1, 0, 1);          drain();
    send(16384, 0, 0, 0, 1, 0, 1);        drain();
    send(-32768, -32768, 1, 1, 1, 0, 1);  drain();
    send(32767, -32768, 0, 1, 1, 0, 1);   drain();

    // Averaging pair, then mode 0 cancels a pending second symbol
    send(16384, 0, 0, 0, 0, 1, 0);
    send(100, -300, 1, 0, 1, 1, 0);
    send(0, 0, 0, 0, 0, 1, 0);
    send(7, 5, 1, 0, 1, 1, 0);
    drain();
    send(1234, -77, 0, 0, 0, 1, 0);
    send(-555, 999, 1, 1, 1, 1, 0);
    send(400, 400, 0, 1, 0, 0, 0);
    send(-3, 8, 1, 0, 1, 0, 0);
    send(2000, 0, 0, 0, 0, 1, 0);
    send(-1, -1, 0, 1, 1, 1, 0);
    send(-2000, 50, 1, 1, 0, 1, 0);
    send(9, -9, 0, 0, 1, 1, 0);
    drain();

    // Back-pressure mid-burst
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(1000 * k - 2500, 3000 - 700 * k, k[0], k[1], k == 5, 0, 0);
      end
      begin
        for (int n = 0; n < 50 && !out_valid0; n++) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready0, 0);
          chk("stall_in_ready_round", in_ready1, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Short symbols, then a full symbol ending at DEPTH-1 without in_last
    for (int k = 0; k < 8; k++) send(37 * k - 100, 11 * k, k[1], k[0], k[1:0] == 2'd3, 0, 0);
    for (int k = 0; k < 8; k++) send(-500 + 123 * k, 250 - 61 * k, k[0], k[2], 0, 0, 0);
    drain();

    // Reset with REs in flight
    for (int k = 0; k < 3; k++) send(321 + k, -654, 0, 0, 0, 0, 0);
    rst = 1'b0;
    sbq.delete();
    model_reset();
    @(negedge clk);
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_out_r", out_r0, 0);
    chk("midrst_out_idx", out_idx0, 0);
    chk("midrst_out_last", out_last0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    send(4096, -4096, 1, 0, 0, 0, 1);
    send(-8192, 77, 0, 1, 1, 0, 0);
    drain();

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
